// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory controller.
//   - request size codes carried on req_size
//   - controller state encoding (also exported on the debug port)
//   - log2 helper used to size the word index from DEPTH_WORDS
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Ceiling log2; DEPTH_WORDS is a power of two so this is exact.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory controller (purely combinational).
// Ports:
//   i_size      request size code (byte/half/word; 11 illegal)
//   i_signed    load extension: 1 = sign-extend, 0 = zero-extend
//   i_addr_lo   byte lane address bits [1:0]
//   i_wdata     store data, value right-justified
//   i_rword     addressed memory word as currently stored
//   o_be        per-lane write enable (all zero on error)
//   o_wword     store data replicated so each enabled lane sees its byte
//   o_ldata     right-justified, extended load data (zero on error)
//   o_err       misaligned address or illegal size
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldata,
  output logic        o_err
);

  logic [31:0] w_shifted;

  // Little-endian: lane n occupies bits 8n+7:8n, so shifting right by 8*lane
  // right-justifies the selected byte or halfword.
  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    o_err = 1'b0;
    case (i_size)
      SZ_BYTE: o_err = 1'b0;
      SZ_HALF: o_err = i_addr_lo[0];
      SZ_WORD: o_err = (i_addr_lo != 2'b00);
      default: o_err = 1'b1;
    endcase
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata;
    o_ldata = 32'h0;
    if (!o_err) begin
      case (i_size)
        SZ_BYTE: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wword = {4{i_wdata[7:0]}};
          o_ldata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
        end
        SZ_HALF: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wword = {2{i_wdata[15:0]}};
          o_ldata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
        default: begin
          o_be    = 4'b1111;
          o_wword = i_wdata;
          o_ldata = i_rword;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores with extension,
// misalignment detection, configurable wait states and a clear-after-reset
// sweep.
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; all request fields are captured on that edge.
// req_ready is high only in IDLE. rsp_valid pulses for one cycle exactly
// WAIT_CYCLES+1 cycles after the acceptance cycle; there is no response
// back-pressure. rsp_rdata/rsp_err hold until the next response.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_signed        load sign-extension select
//   req_addr          byte address (upper bits beyond the array wrap)
//   req_wdata         store data
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         extended load data; 0 for stores and errors
//   rsp_err           misaligned or illegal size
//   o_dbg_state       current controller state
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int WAIT_CYCLES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        o_dbg_state
);

  localparam int     IDX_W     = log2(DEPTH_WORDS);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [31:0]       r_mem [DEPTH_WORDS];

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ready;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [3:0]        r_wait_cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_in_idle;
  logic              w_accept;
  logic              w_go_resp;
  logic              w_write;
  logic [1:0]        w_size;
  logic              w_signed;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic [31:0]       w_ldata;
  logic              w_err;
  logic              w_unused_addr;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle & r_ready & req_valid;

  // With WAIT_CYCLES=0 the access happens on the acceptance edge itself, so
  // the live request fields are used while still in IDLE.
  assign w_write  = w_in_idle ? req_write  : r_write;
  assign w_size   = w_in_idle ? req_size   : r_size;
  assign w_signed = w_in_idle ? req_signed : r_signed;
  assign w_addr   = w_in_idle ? req_addr   : r_addr;
  assign w_wdata  = w_in_idle ? req_wdata  : r_wdata;

  assign w_idx         = w_addr[IDX_W+1:2];
  assign w_unused_addr = ^w_addr;

  assign w_go_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == ST_WAIT) && (r_wait_cnt == 4'(WAIT_CYCLES - 1)));

  dmem_lane_align u_align (
    .i_size    (w_size),
    .i_signed  (w_signed),
    .i_addr_lo (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_ldata   (w_ldata),
    .o_err     (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (w_go_resp) w_state_nxt = ST_RESP;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_ready     <= 1'b0;
      r_clr_idx   <= '0;
      r_wait_cnt  <= '0;
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_go_resp;
      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
      if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      else                    r_wait_cnt <= '0;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (w_go_resp) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_write | w_err) ? 32'h0 : w_ldata;
      end
    end
  end

  // Storage has no reset; the sweep (or the first store) defines contents.
  // An in-flight store is only committed on the edge entering RESP, which
  // reset can never reach, so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_go_resp && w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  assign req_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int DEPTH = 256;
  localparam int WAITC = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference memory: one 32-bit word per index, little-endian bytes.
  logic [31:0] mem_m [DEPTH];

  dmem_ctrl #(
    .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model of one access, straight from the addressing rules.
  function automatic void model_access(input bit wr, input logic [1:0] sz, input bit sg,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit er);
    int unsigned idx;
    int unsigned off;
    logic [31:0] word, mask, val;
    idx = (a / 4) % DEPTH;
    off = a % 4;
    rd  = 32'h0;
    er  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    if (er) return;
    word = mem_m[idx];
    if (wr) begin
      case (sz)
        2'd0:    begin mask = 32'hFF   << (8*off); val = (wd & 32'hFF)   << (8*off); end
        2'd1:    begin mask = 32'hFFFF << (8*off); val = (wd & 32'hFFFF) << (8*off); end
        default: begin mask = 32'hFFFF_FFFF;       val = wd;                       end
      endcase
      mem_m[idx] = (word & ~mask) | (val & mask);
    end else begin
      case (sz)
        2'd0: begin
          val = (word >> (8*off)) & 32'hFF;
          if (sg && val >= 32'h80) val = val | 32'hFFFF_FF00;
        end
        2'd1: begin
          val = (word >> (8*off)) & 32'hFFFF;
          if (sg && val >= 32'h8000) val = val | 32'hFFFF_0000;
        end
        default: val = word;
      endcase
      rd = val;
    end
  endfunction

  // ---------------- driver ----------------
  // Drives one request at a falling edge, returns the response and the
  // number of cycles from the acceptance cycle to rsp_valid (99 on timeout).
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int lat);
    int guard;
    rd = 32'h0; er = 1'b0; lat = 99;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    check("rsp_pulse_width", {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic run_and_check(input string name, input bit wr, input logic [1:0] sz,
                               input bit sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input bit exp_er);
    logic [31:0] rd;
    bit er;
    int lat;
    do_req(wr, sz, sg, a, wd, rd, er, lat);
    check({name, "_lat"},   lat,           WAITC + 1);
    check({name, "_rdata"}, rd,            exp_rd);
    check({name, "_err"},   {31'h0, er},   {31'h0, exp_er});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt;
    bit saw_valid;
    logic [31:0] m_rd;
    bit m_er;

    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

    vecs.push_back('{"ld_top_cleared", 0, 2'd2, 0, 32'h3FC, 32'h0,        32'h0000_0000, 0});
    vecs.push_back('{"st_w_10",        1, 2'd2, 0, 32'h10,  32'h12345678, 32'h0,         0});
    vecs.push_back('{"ld_w_10",        0, 2'd2, 0, 32'h10,  32'h0,        32'h1234_5678, 0});
    vecs.push_back('{"ld_b_13_s",      0, 2'd0, 1, 32'h13,  32'h0,        32'h0000_0012, 0});
    vecs.push_back('{"ld_h_10_s",      0, 2'd1, 1, 32'h10,  32'h0,        32'h0000_5678, 0});
    vecs.push_back('{"st_b_11",        1, 2'd0, 0, 32'h11,  32'hFFFF_FF80, 32'h0,        0});
    vecs.push_back('{"ld_b_11_s",      0, 2'd0, 1, 32'h11,  32'h0,        32'hFFFF_FF80, 0});
    vecs.push_back('{"ld_b_11_u",      0, 2'd0, 0, 32'h11,  32'h0,        32'h0000_0080, 0});
    vecs.push_back('{"ld_w_10_b",      0, 2'd2, 0, 32'h10,  32'h0,        32'h1234_8078, 0});
    vecs.push_back('{"st_h_21_mis",    1, 2'd1, 0, 32'h21,  32'h0000_BEEF, 32'h0,        1});
    vecs.push_back('{"ld_w_20_unch",   0, 2'd2, 0, 32'h20,  32'h0,        32'h0000_0000, 0});
    vecs.push_back('{"ld_sz11",        0, 2'd3, 0, 32'h30,  32'h0,        32'h0,         1});
    vecs.push_back('{"ld_w_402_mis",   0, 2'd2, 0, 32'h402, 32'h0,        32'h0,         1});
    vecs.push_back('{"st_w_400_wrap",  1, 2'd2, 0, 32'h400, 32'hCAFEF00D, 32'h0,         0});
    vecs.push_back('{"ld_w_0_wrap",    0, 2'd2, 0, 32'h0,   32'h0,        32'hCAFE_F00D, 0});
    vecs.push_back('{"st_h_12",        1, 2'd1, 0, 32'h12,  32'hFFFF_A5C3, 32'h0,        0});
    vecs.push_back('{"ld_w_10_c",      0, 2'd2, 0, 32'h10,  32'h0,        32'hA5C3_8078, 0});
    vecs.push_back('{"ld_h_12_s",      0, 2'd1, 1, 32'h12,  32'h0,        32'hFFFF_A5C3, 0});
    vecs.push_back('{"ld_h_12_u",      0, 2'd1, 0, 32'h12,  32'h0,        32'h0000_A5C3, 0});
    vecs.push_back('{"ld_w_10_sgn",    0, 2'd2, 1, 32'h10,  32'h0,        32'hA5C3_8078, 0});

    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata,          32'h0);
    check("rst_err",   {31'h0, rsp_err},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (req_ready) break;
    end
    check("clear_cycles", cnt, DEPTH);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      model_access(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, m_rd, m_er);
      run_and_check(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_er);
    end

    // ---------------- random vs model ----------------
    for (int n = 0; n < 200; n++) begin
      bit          wr;
      logic [1:0]  sz;
      bit          sg;
      logic [31:0] a;
      logic [31:0] wd;
      wr = ($urandom_range(0, 1) == 1);
      sz = 2'($urandom_range(0, 3));
      sg = ($urandom_range(0, 1) == 1);
      a  = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 3)) << 10);
      wd = $urandom;
      model_access(wr, sz, sg, a, wd, m_rd, m_er);
      run_and_check("rand", wr, sz, sg, a, wd, m_rd, m_er);
    end

    // ---------------- reset during WAIT of a store ----------------
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'h0, req_ready}, 32'h0);
    check("midrst_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_rdata", rsp_rdata,          32'h0);
    check("midrst_err",   {31'h0, rsp_err},   32'h0);
    saw_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    cnt = 0;
    while (cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rsp_valid) saw_valid = 1'b1;
      if (req_ready) break;
    end
    check("midrst_no_rsp", {31'h0, saw_valid}, 32'h0);
    check("midrst_clear_cycles", cnt, DEPTH);
    run_and_check("midrst_ld_40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    run_and_check("midrst_ld_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the MIPS datapath, succeeding the single-cycle word-only data memory. Adds byte/halfword/word access with sign or zero extension and misalignment detection. Adds a valid/ready request port with configurable wait-state latency, plus a sequential clear-after-reset sweep. Sits between the ALU address/rt-data outputs and the register write-back mux.

Parameters:
ADDR_W, 32, request address width in bits.
DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 2.
WAIT_CYCLES, 1, extra cycles between request acceptance and access; 0..15.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = skip the sweep.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
req_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address (ALU result).
req_wdata  in  32  store data; value in low bits for byte/half.
rsp_valid  out  1  one-cycle pulse marking a completed request.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned address or illegal size, qualified by rsp_valid.

Behaviour:
- Reset (rst_n low, async):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Counters are zeroed.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Any in-flight request is dropped; an uncommitted store is never written.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to word clr_idx each cycle, clr_idx 0..DEPTH_WORDS-1.
  - req_ready=0.
  - After the last word, go to IDLE. Lasts exactly DEPTH_WORDS cycles after reset release.
- IDLE:
  - req_ready=1.
  - Acceptance = req_valid & req_ready at a rising edge; all request fields are captured into registers.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter counts WAIT_CYCLES cycles, then goes to RESP.
- Access is performed on the edge that enters RESP:
  - Store: byte-enabled write.
  - Load: read, then extend.
  - rsp_* are registered on the same edge.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - rsp_rdata and rsp_err hold their value until the next RESP.
- Latency and throughput:
  - rsp_valid is high WAIT_CYCLES+1 cycles after the acceptance cycle.
  - At most one request per WAIT_CYCLES+2 cycles.
  - No response back-pressure.
- Addressing:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
  - Byte lane = req_addr[1:0], little-endian: lane 0 = bits 7:0.
  - Halfword uses lanes 0-1 or 2-3.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - req_size=11 is always an error.
  - On error: no memory write, rsp_rdata=0, rsp_err=1, normal latency.
- Stores:
  - Byte writes wdata[7:0] to its lane only.
  - Half writes wdata[15:0] to its two lanes.
  - Other lanes are unchanged.
- Loads:
  - The selected lane(s) are right-justified.
  - Upper bits are filled with the MSB of the selected field if req_signed=1, else with 0.
  - req_signed is ignored for word loads.
- Inputs are ignored when req_ready=0; the master must hold req_valid until accepted.

Decomposition:
- Shared package mips_mem_pkg:
  - Size codes: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP.
  - Function log2 for index width.
- One natural sub-module: dmem_lane_align.
  - Purely combinational.
  - Computes the store byte-enable and shifted write word, the load extract/extend result, and the misalignment flag.
- The FSM, counters and storage array stay in dmem_ctrl.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH_WORDS=256 -> req_ready low for 256 cycles, then high; word load of 0x3FC returns 0x00000000.
- WAIT_CYCLES=1: store word 0x12345678 at 0x10 accepted at cycle t -> rsp_valid only at t+2 with rsp_err=0; word load of 0x10 returns 0x12345678.
- Sub-word loads from 0x12345678:
  - byte at 0x13, signed -> 0x00000012;
  - halfword at 0x10, signed -> 0x00005678;
  - after storing byte 0x80 at 0x11, signed byte load of 0x11 -> 0xFFFFFF80, unsigned -> 0x00000080, word load of 0x10 -> 0x12348078.
- Errors:
  - halfword store at 0x21 -> rsp_err=1, rsp_rdata=0, word 0x20 unchanged;
  - req_size=11 -> rsp_err=1;
  - word load at 0x402 -> rsp_err=1.
- Address wrap: store word 0xCAFEF00D at 0x400 -> word load of 0x000 returns 0xCAFEF00D.
- Reset mid-operation: assert rst_n low during WAIT of a store of 0xDEADBEEF at 0x40 -> rsp_valid never pulses; after the clear sweep, load of 0x40 returns 0.
